// File: rtl/wb_bus_fabric.sv
// Wishbone B4 classic fabric: round-robin master arbiter, base/mask slave decoder
// and bus watchdog. Unmapped addresses and hung slaves are answered with err.
module wb_bus_fabric #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 6,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
   parameter int TIMEOUT   = 255
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_i,
   input  logic [N_MASTERS*ADDR_W-1:0]     m_adr_i,
   input  logic [N_MASTERS*DATA_W-1:0]     m_dat_i,
   input  logic [N_MASTERS*DATA_W/8-1:0]   m_sel_i,
   input  logic [N_MASTERS-1:0]            m_we_i,
   input  logic [N_MASTERS-1:0]            m_cyc_i,
   input  logic [N_MASTERS-1:0]            m_stb_i,
   output logic [N_MASTERS*DATA_W-1:0]     m_dat_o,
   output logic [N_MASTERS-1:0]            m_ack_o,
   output logic [N_MASTERS-1:0]            m_err_o,
   output logic [N_MASTERS-1:0]            m_rty_o,
   output logic [N_SLAVES*ADDR_W-1:0]      s_adr_o,
   output logic [N_SLAVES*DATA_W-1:0]      s_dat_o,
   output logic [N_SLAVES*DATA_W/8-1:0]    s_sel_o,
   output logic [N_SLAVES-1:0]             s_we_o,
   output logic [N_SLAVES-1:0]             s_cyc_o,
   output logic [N_SLAVES-1:0]             s_stb_o,
   input  logic [N_SLAVES*DATA_W-1:0]      s_dat_i,
   input  logic [N_SLAVES-1:0]             s_ack_i,
   input  logic [N_SLAVES-1:0]             s_err_i,
   input  logic [N_SLAVES-1:0]             s_rty_i,
   output logic                            timeout_o
);
   localparam int SEL_W = DATA_W / 8;
   localparam int GW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q;
   logic [GW-1:0]     gnt_q, rr_q, pick, cand;
   logic [15:0]       wdog_q;
   logic              miss_err_q, wd_fire_q, wd_block_q;

   logic              busy;
   logic [ADDR_W-1:0] g_adr;
   logic [DATA_W-1:0] g_dat;
   logic [SEL_W-1:0]  g_sel;
   logic              g_we, g_cyc, g_stb;
   logic [SW-1:0]     slv_idx;
   logic              slv_hit;
   logic              resp_en, r_ack, r_err, r_rty, stall;

   assign busy      = (state_q == BUSY);
   assign timeout_o = wd_fire_q;

   always_comb begin
      g_adr = m_adr_i[int'(gnt_q)*ADDR_W +: ADDR_W];
      g_dat = m_dat_i[int'(gnt_q)*DATA_W +: DATA_W];
      g_sel = m_sel_i[int'(gnt_q)*SEL_W +: SEL_W];
      g_we  = m_we_i[gnt_q];
      g_cyc = m_cyc_i[gnt_q];
      g_stb = m_stb_i[gnt_q];
   end

   // Scan downward from the rr pointer's furthest offset so the nearest requester wins.
   always_comb begin
      pick = rr_q;
      cand = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         cand = GW'((int'(rr_q) + i) % N_MASTERS);
         if (m_cyc_i[cand]) pick = cand;
      end
   end

   always_comb begin
      slv_hit = 1'b0;
      slv_idx = '0;
      for (int k = N_SLAVES - 1; k >= 0; k--) begin
         if ((g_adr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
            slv_hit = 1'b1;
            slv_idx = SW'(k);
         end
      end
   end

   // After the watchdog fires the slave stays cut off until the master drops stb,
   // so a late response cannot leak into the next transfer.
   always_comb begin
      resp_en = busy && g_cyc && g_stb && slv_hit && !wd_block_q;
      r_err   = resp_en && s_err_i[slv_idx];
      r_ack   = resp_en && s_ack_i[slv_idx] && !s_err_i[slv_idx];
      r_rty   = resp_en && s_rty_i[slv_idx] && !s_err_i[slv_idx];
      stall   = resp_en && !(s_ack_i[slv_idx] || s_err_i[slv_idx] || s_rty_i[slv_idx]);
   end

   always_comb begin
      s_adr_o = {N_SLAVES{g_adr}};
      s_dat_o = {N_SLAVES{g_dat}};
      s_sel_o = {N_SLAVES{g_sel}};
      s_we_o  = {N_SLAVES{g_we}};
      s_cyc_o = '0;
      s_stb_o = '0;
      m_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      if (busy && g_cyc && slv_hit && !wd_block_q) begin
         s_cyc_o[slv_idx] = 1'b1;
         s_stb_o[slv_idx] = g_stb;
      end
      if (busy && g_cyc && slv_hit)
         m_dat_o[int'(gnt_q)*DATA_W +: DATA_W] = s_dat_i[int'(slv_idx)*DATA_W +: DATA_W];
      m_ack_o[gnt_q] = r_ack;
      m_err_o[gnt_q] = r_err || miss_err_q || wd_fire_q;
      m_rty_o[gnt_q] = r_rty;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         rr_q       <= '0;
         wdog_q     <= '0;
         miss_err_q <= 1'b0;
         wd_fire_q  <= 1'b0;
         wd_block_q <= 1'b0;
      end else begin
         miss_err_q <= busy && g_cyc && g_stb && !slv_hit && !miss_err_q;
         wd_fire_q  <= 1'b0;
         if (stall) begin
            if (wdog_q == 16'(TIMEOUT - 1)) begin
               wdog_q     <= '0;
               wd_fire_q  <= 1'b1;
               wd_block_q <= 1'b1;
            end else begin
               wdog_q <= wdog_q + 16'd1;
            end
         end else begin
            wdog_q <= '0;
         end
         if (wd_block_q && !wd_fire_q && !(busy && g_cyc && g_stb))
            wd_block_q <= 1'b0;
         case (state_q)
            IDLE: if (|m_cyc_i) begin
               state_q <= BUSY;
               gnt_q   <= pick;
            end
            BUSY: if (!g_cyc) begin
               state_q <= IDLE;
               rr_q    <= (int'(gnt_q) == N_MASTERS - 1) ? '0 : gnt_q + GW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_bus_fabric.sv
// Bench for wb_bus_fabric: directed scenarios followed by random transfers
// scored against a per-slave word-memory reference model.
`timescale 1ns/1ps
module tb_wb_bus_fabric;
   localparam int NM = 2;
   localparam int NS = 6;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000,
                                        32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000,
                                        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

   logic              clk = 1'b0;
   logic              rst;
   logic [NM*AW-1:0]  m_adr;
   logic [NM*DW-1:0]  m_dat;
   logic [NM*4-1:0]   m_sel;
   logic [NM-1:0]     m_we, m_cyc, m_stb;
   logic [NM*DW-1:0]  m_rdat;
   logic [NM-1:0]     m_ack, m_err, m_rty;
   logic [NS*AW-1:0]  s_adr;
   logic [NS*DW-1:0]  s_dat, s_rdat;
   logic [NS*4-1:0]   s_sel;
   logic [NS-1:0]     s_we, s_cyc, s_stb;
   logic [NS-1:0]     s_ack, s_err, s_rty;
   logic              timeout;

   logic [NS-1:0]     ack_q, hang, inj_ack, inj_err;
   logic              mem_clr;
   logic [31:0]       mem [NS][16];
   logic [31:0]       ref_mem [NS][16];
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   wb_bus_fabric #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
                   .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
      .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb),
      .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .timeout_o(timeout)
   );

   // Behavioural slaves: registered ack one cycle after stb unless hung.
   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) begin
         if (mem_clr) begin
            for (int w = 0; w < 16; w++) mem[k][w] <= '0;
         end
         if (rst) begin
            ack_q[k] <= 1'b0;
         end else begin
            ack_q[k] <= s_cyc[k] && s_stb[k] && !ack_q[k] && !hang[k];
            if (s_cyc[k] && s_stb[k] && s_we[k] && !ack_q[k] && !hang[k])
               mem[k][s_adr[k*AW+2 +: 4]] <= s_dat[k*DW +: DW];
         end
      end
   end

   always_comb begin
      s_rdat = '0;
      for (int k = 0; k < NS; k++) s_rdat[k*DW +: DW] = mem[k][s_adr[k*AW+2 +: 4]];
   end

   assign s_ack = ack_q | inj_ack;
   assign s_err = inj_err;
   assign s_rty = '0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
      m_adr[m*AW +: AW] = adr;
      m_dat[m*DW +: DW] = dat;
      m_sel[m*4 +: 4]   = 4'hF;
      m_we[m]  = we;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
   endtask

   task automatic releaseMaster(input int m);
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m]  = 1'b0;
   endtask

   task automatic runTransfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              output logic ack, output logic err, output logic [31:0] rdat, output int lat,
                              output logic [NS-1:0] cyc_seen, output logic [31:0] adr_seen,
                              output logic other_seen);
      ack = 1'b0; err = 1'b0; rdat = '0; lat = 0;
      cyc_seen = '0; adr_seen = '0; other_seen = 1'b0;
      applyStimulus(m, we, adr, dat);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            cyc_seen = s_cyc;
            adr_seen = s_adr[AW-1:0];
         end
         if (m_ack[1-m] || m_err[1-m] || m_rty[1-m] || (m_rdat[(1-m)*DW +: DW] != '0))
            other_seen = 1'b1;
         if (m_ack[m] || m_err[m]) begin
            ack  = m_ack[m];
            err  = m_err[m];
            rdat = m_rdat[m*DW +: DW];
            lat  = c;
            break;
         end
      end
      releaseMaster(m);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      logic          ack, err, other;
      logic [31:0]   rdat, adr_seen, adr, dat;
      logic [NS-1:0] cyc_seen;
      int            lat, m, tgt, word, k;
      logic          we;

      rst = 1'b1; mem_clr = 1'b1;
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
      hang = 6'b000100; inj_ack = '0; inj_err = '0;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < 16; w++) ref_mem[s][w] = '0;

      // A master requesting during reset must not be granted.
      applyStimulus(0, 1'b0, 32'h0001_0000, '0);
      repeat (3) @(negedge clk);
      checkOutput("reset_s_cyc", 64'(s_cyc), 64'd0);
      checkOutput("reset_m_ack", 64'(m_ack), 64'd0);
      checkOutput("reset_m_err", 64'(m_err), 64'd0);
      checkOutput("reset_timeout", 64'(timeout), 64'd0);
      releaseMaster(0);
      @(negedge clk);
      rst = 1'b0; mem_clr = 1'b0;
      @(negedge clk);

      // Simultaneous requests straight after reset: master0 first, master1 after it leaves.
      applyStimulus(0, 1'b0, 32'h0001_0004, '0);
      applyStimulus(1, 1'b0, 32'h0000_000C, '0);
      @(negedge clk);
      checkOutput("arb_first_grant_cyc", 64'(s_cyc), 64'b000010);
      @(negedge clk);
      checkOutput("arb_first_ack", 64'(m_ack), 64'b01);
      releaseMaster(0);
      lat = 0; cyc_seen = '0; other = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 2) cyc_seen = s_cyc;
         if (m_ack[0]) other = 1'b1;
         if (m_ack[1]) begin lat = c; break; end
      end
      checkOutput("arb_second_grant_cyc", 64'(cyc_seen), 64'b000001);
      checkOutput("arb_second_latency", 64'(lat), 64'd3);
      checkOutput("arb_no_stray_ack_m0", 64'(other), 64'd0);
      releaseMaster(1);
      @(negedge clk);

      // Write then read back through slave1.
      runTransfer(0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, ack, err, rdat, lat, cyc_seen, adr_seen, other);
      ref_mem[1][1] = 32'hDEAD_BEEF;
      checkOutput("wr_s_cyc", 64'(cyc_seen), 64'b000010);
      checkOutput("wr_ack", 64'({ack, err}), 64'b10);
      checkOutput("wr_latency", 64'(lat), 64'd2);
      runTransfer(0, 1'b0, 32'h0001_0004, '0, ack, err, rdat, lat, cyc_seen, adr_seen, other);
      checkOutput("rd_ack", 64'({ack, err}), 64'b10);
      checkOutput("rd_data", 64'(rdat), 64'hDEAD_BEEF);

      // Overlapping decode: slaves 0 and 3 both match, lowest index wins.
      runTransfer(0, 1'b0, 32'h0000_0008, '0, ack, err, rdat, lat, cyc_seen, adr_seen, other);
      checkOutput("overlap_s_cyc", 64'(cyc_seen), 64'b000001);
      checkOutput("overlap_ack", 64'({ack, err}), 64'b10);

      // Unmapped address: err exactly one cycle, even with stb still held.
      applyStimulus(0, 1'b0, 32'h9000_0000, '0);
      @(negedge clk);
      checkOutput("miss_s_cyc", 64'(s_cyc), 64'd0);
      checkOutput("miss_err_not_early", 64'(m_err), 64'd0);
      @(negedge clk);
      checkOutput("miss_err_pulse", 64'(m_err), 64'b01);
      checkOutput("miss_no_ack", 64'(m_ack), 64'd0);
      @(negedge clk);
      checkOutput("miss_err_one_cycle", 64'(m_err), 64'd0);
      releaseMaster(0);
      @(negedge clk);

      // Hung slave2: watchdog fires TIMEOUT cycles after stb reaches it; a late ack is dropped.
      applyStimulus(0, 1'b0, 32'h0002_0000, '0);
      lat = 0; cyc_seen = '0; other = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) cyc_seen = s_cyc;
         if (m_err[0] && !timeout) other = 1'b1;
         if (timeout) begin lat = c; break; end
      end
      checkOutput("wdog_s_cyc", 64'(cyc_seen), 64'b000100);
      checkOutput("wdog_no_early_err", 64'(other), 64'd0);
      checkOutput("wdog_latency", 64'(lat), 64'(1 + TO));
      checkOutput("wdog_err", 64'(m_err), 64'b01);
      checkOutput("wdog_kill_s_cyc", 64'(s_cyc), 64'd0);
      inj_ack[2] = 1'b1;
      @(negedge clk);
      checkOutput("wdog_late_ack_ignored", 64'(m_ack), 64'd0);
      checkOutput("wdog_err_one_cycle", 64'(m_err), 64'd0);
      checkOutput("wdog_timeout_one_cycle", 64'(timeout), 64'd0);
      inj_ack = '0;
      releaseMaster(0);
      @(negedge clk);

      // Slave4 raises ack and err together: err wins.
      inj_ack[4] = 1'b1; inj_err[4] = 1'b1;
      applyStimulus(1, 1'b0, 32'h1000_0000, '0);
      @(negedge clk);
      checkOutput("ackerr_err", 64'(m_err), 64'b10);
      checkOutput("ackerr_ack", 64'(m_ack), 64'b00);
      releaseMaster(1);
      inj_ack = '0; inj_err = '0;
      @(negedge clk);

      // Reset while master1 waits on slave0, then master0 must win after release.
      hang[0] = 1'b1;
      applyStimulus(1, 1'b0, 32'h0000_0010, '0);
      @(negedge clk);
      checkOutput("rstmid_s_cyc_before", 64'(s_cyc), 64'b000001);
      @(negedge clk);
      rst = 1'b1; inj_ack[0] = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_s_cyc", 64'(s_cyc), 64'd0);
      checkOutput("rstmid_m_ack", 64'(m_ack), 64'd0);
      checkOutput("rstmid_m_err", 64'(m_err), 64'd0);
      rst = 1'b0; inj_ack = '0; hang[0] = 1'b0;
      applyStimulus(0, 1'b0, 32'h0001_0004, '0);
      @(negedge clk);
      checkOutput("rstmid_regrant_m0", 64'(s_cyc), 64'b000010);
      @(negedge clk);
      checkOutput("rstmid_regrant_ack", 64'(m_ack), 64'b01);
      checkOutput("rstmid_regrant_data", 64'(m_rdat[DW-1:0]), 64'hDEAD_BEEF);
      releaseMaster(0); releaseMaster(1);
      @(negedge clk);

      // Random traffic from both masters over the mapped slaves and an unmapped region.
      for (int t = 0; t < 40; t++) begin
         m    = int'($urandom_range(0, 1));
         tgt  = int'($urandom_range(0, 5));
         word = int'($urandom_range(0, 15));
         we   = 1'($urandom_range(0, 1));
         dat  = $urandom;
         case (tgt)
            0:       begin k = 0;  adr = 32'h0000_0000 | 32'(word << 2); end
            1:       begin k = 1;  adr = 32'h0001_0000 | 32'(word << 2); end
            2:       begin k = 3;  adr = 32'h0050_0000 | 32'(word << 2); end
            3:       begin k = 4;  adr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFC0) | 32'(word << 2); end
            4:       begin k = 5;  adr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFC0) | 32'(word << 2); end
            default: begin k = -1; adr = 32'h9000_0000 | 32'(word << 2); end
         endcase
         runTransfer(m, we, adr, dat, ack, err, rdat, lat, cyc_seen, adr_seen, other);
         checkOutput("rand_latency", 64'(lat), 64'd2);
         checkOutput("rand_other_master_quiet", 64'(other), 64'd0);
         if (k < 0) begin
            checkOutput("rand_miss_resp", 64'({ack, err}), 64'b01);
            checkOutput("rand_miss_s_cyc", 64'(cyc_seen), 64'd0);
         end else begin
            checkOutput("rand_hit_resp", 64'({ack, err}), 64'b10);
            checkOutput("rand_hit_s_cyc", 64'(cyc_seen), 64'(1 << k));
            checkOutput("rand_s_adr", 64'(adr_seen), 64'(adr));
            if (we) ref_mem[k][word] = dat;
            else    checkOutput("rand_rd_data", 64'(rdat), 64'(ref_mem[k][word]));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
